// File: rtl/mem_access_defs.sv
// Shared definitions for the memory access unit: FSM state encodings and wait limit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_access_defs;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Cycles spent in REQ without mem_done before the access is abandoned.
    localparam int MAX_WAIT_DEF = 15;

endpackage

// File: rtl/mem_access_dff.sv
// Generic synchronous-reset register; every state element in the unit is built from it.
// Latency: 1 cycle (d visible on q after the next rising edge).
// Backpressure: none; loads every cycle.
// Ports: clk, rst (sync, active-high, clears q to 0), d [W-1:0], q [W-1:0].
module mem_access_dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_access_fsm.sv
// Control FSM (IDLE/REQ/DONE) and REQ wait counter for the memory access unit.
// Latency: REQ entered one cycle after start_mem; DONE one cycle after mem_done or timeout.
// Backpressure: holds in REQ until mem_done or MAX_WAIT cycles, DONE lasts one cycle.
// Ports: clk, rst, start_mem (accepted memory op), mem_done, state, done_hit, timeout.
module mem_access_fsm
    import mem_access_defs::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start_mem,
    input  logic   mem_done,
    output state_e state,
    output logic   done_hit,
    output logic   timeout
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    state_e        state_nxt;

    assign state = state_e'(state_q);

    // mem_done takes priority over the limit, so a response arriving on the
    // last permitted cycle still completes normally.
    assign done_hit = (state == REQ) && mem_done;
    assign timeout  = (state == REQ) && !mem_done && (cnt_q == CW'(MAX_WAIT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_mem) state_nxt = REQ;
            REQ:     if (done_hit || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign state_d = state_nxt;
    // Counter runs only while staying in REQ, so it reads 0 on the first REQ cycle.
    assign cnt_d   = ((state == REQ) && (state_nxt == REQ)) ? cnt_q + CW'(1) : '0;

    mem_access_dff #(.W(2))  u_state_ff (.clk(clk), .rst(rst), .d(state_d), .q(state_q));
    mem_access_dff #(.W(CW)) u_cnt_ff   (.clk(clk), .rst(rst), .d(cnt_d),   .q(cnt_q));

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage: turns execute results into a single memory request and a writeback beat.
// Latency: non-memory ops 1 cycle; memory ops mem-latency+1 to writeback, period mem-latency+2.
// Backpressure: ex_ready is high only in IDLE; ex_valid is ignored while an access is in flight.
// Ports: clk, rst; ex_* execute inputs / ex_ready; mem_req/mem_wr/mem_addr/mem_wdata,
//        mem_done/mem_rdata; wb_valid/wb_data/wb_err.
// Option: define ALIGN_CHECK_EN to reject odd-address loads/stores with wb_err.
module mem_access_unit
    import mem_access_defs::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [15:0] ex_alu_result,
    input  logic [15:0] ex_store_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_err,
    output logic        ex_ready,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic        wb_valid,
    output logic [15:0] wb_data,
    output logic        wb_err
);

    state_e      state;
    logic        done_hit;
    logic        timeout;

    logic        xfer;
    logic        is_mem;
    logic        misalign;
    logic        bad_op;
    logic        start_mem;

    logic [15:0] addr_q,  addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        wr_q,    wr_d;
    logic        err_q,   err_d;

    logic        wb_valid_d;
    logic [15:0] wb_data_d;
    logic        wb_err_d;

    assign ex_ready = (state == IDLE);
    assign xfer     = ex_valid && ex_ready;
    assign is_mem   = ex_mem_read || ex_mem_write;

`ifdef ALIGN_CHECK_EN
    assign misalign = is_mem && ex_alu_result[0];
`else
    assign misalign = 1'b0;
`endif

    // Read+write together or a misaligned address never reaches the memory.
    assign bad_op    = (ex_mem_read && ex_mem_write) || misalign;
    assign start_mem = xfer && is_mem && !bad_op;

    mem_access_fsm #(.MAX_WAIT(MAX_WAIT)) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .start_mem (start_mem),
        .mem_done  (mem_done),
        .state     (state),
        .done_hit  (done_hit),
        .timeout   (timeout)
    );

    // Request latches: loaded only when a memory op is accepted.
    assign addr_d  = start_mem ? ex_alu_result : addr_q;
    assign wdata_d = start_mem ? ex_store_data : wdata_q;
    assign wr_d    = start_mem ? ex_mem_write  : wr_q;
    assign err_d   = start_mem ? ex_err        : err_q;

    mem_access_dff #(.W(16)) u_addr_ff  (.clk(clk), .rst(rst), .d(addr_d),  .q(addr_q));
    mem_access_dff #(.W(16)) u_wdata_ff (.clk(clk), .rst(rst), .d(wdata_d), .q(wdata_q));
    mem_access_dff #(.W(1))  u_wr_ff    (.clk(clk), .rst(rst), .d(wr_d),    .q(wr_q));
    mem_access_dff #(.W(1))  u_err_ff   (.clk(clk), .rst(rst), .d(err_d),   .q(err_q));

    assign mem_req   = (state == REQ);
    assign mem_wr    = mem_req && wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Writeback beat is registered; it fires the cycle after an immediate
    // completion and on the single DONE cycle after a memory access.
    always_comb begin
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data;
        wb_err_d   = 1'b0;
        if (xfer && !is_mem) begin
            wb_valid_d = 1'b1;
            wb_data_d  = ex_alu_result;
            wb_err_d   = ex_err;
        end else if (xfer && bad_op) begin
            wb_valid_d = 1'b1;
            wb_data_d  = 16'h0000;
            wb_err_d   = 1'b1;
        end else if (done_hit) begin
            wb_valid_d = 1'b1;
            // Stores return their address; loads return the read data.
            wb_data_d  = wr_q ? addr_q : mem_rdata;
            wb_err_d   = err_q;
        end else if (timeout) begin
            wb_valid_d = 1'b1;
            wb_data_d  = 16'h0000;
            wb_err_d   = 1'b1;
        end
    end

    mem_access_dff #(.W(1))  u_wbv_ff (.clk(clk), .rst(rst), .d(wb_valid_d), .q(wb_valid));
    mem_access_dff #(.W(16)) u_wbd_ff (.clk(clk), .rst(rst), .d(wb_data_d),  .q(wb_data));
    mem_access_dff #(.W(1))  u_wbe_ff (.clk(clk), .rst(rst), .d(wb_err_d),   .q(wb_err));

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: reset, non-memory ops, load, store, timeout,
// done-at-limit, reset during REQ, read+write error and alignment behaviour.
// Inputs change 1ns after the rising edge; outputs are checked at the same point.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [15:0] ex_alu_result;
    logic [15:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_err;
    logic        ex_ready;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic        wb_err;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MAX_WAIT(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_err        (ex_err),
        .ex_ready      (ex_ready),
        .mem_req       (mem_req),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_done      (mem_done),
        .mem_rdata     (mem_rdata),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .wb_err        (wb_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [15:0] alu, input logic [15:0] sd,
                           input logic rd, input logic wr, input logic err);
        ex_valid      = 1'b1;
        ex_alu_result = alu;
        ex_store_data = sd;
        ex_mem_read   = rd;
        ex_mem_write  = wr;
        ex_err        = err;
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_valid = 1'b0; ex_alu_result = 16'h0; ex_store_data = 16'h0;
        ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_err = 1'b0;
        mem_done = 1'b0; mem_rdata = 16'h0;
        step(); step();
        rst = 1'b0;
        vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ex_ready got %b want 1", ex_ready); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        vectors++; if (mem_wr !== 1'b0) begin miscompares++; $display("FAIL reset_mem_wr got %b want 0", mem_wr); end
        vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
        vectors++; if (wb_err !== 1'b0) begin miscompares++; $display("FAIL reset_wb_err got %b want 0", wb_err); end
        vectors++; if (wb_data !== 16'h0000) begin miscompares++; $display("FAIL reset_wb_data got %h want 0000", wb_data); end
    endtask

    task automatic test_nonmem();
        present(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL nonmem_wb_valid got %b want 1", wb_valid); end
        vectors++; if (wb_data !== 16'h1234) begin miscompares++; $display("FAIL nonmem_wb_data got %h want 1234", wb_data); end
        vectors++; if (wb_err !== 1'b0) begin miscompares++; $display("FAIL nonmem_wb_err got %b want 0", wb_err); end
        vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("FAIL nonmem_ex_ready got %b want 1", ex_ready); end
        // Second op with ex_err set, back to back.
        present(16'h5678, 16'h0000, 1'b0, 1'b0, 1'b1);
        step();
        vectors++; if (wb_data !== 16'h5678 || wb_err !== 1'b1) begin miscompares++; $display("FAIL nonmem_err got %h/%b want 5678/1", wb_data, wb_err); end
        ex_valid = 1'b0; ex_err = 1'b0;
        // Stray mem_done while IDLE must not do anything.
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        vectors++; if (wb_valid !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL idle_done got wbv=%b req=%b want 0/0", wb_valid, mem_req); end
    endtask

    task automatic test_load();
        int low = 0;
        present(16'h0040, 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        // Non-memory op offered during REQ must be ignored.
        present(16'h9999, 16'h0000, 1'b0, 1'b0, 1'b0);
        vectors++; if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0040) begin miscompares++; $display("FAIL load_req got req=%b wr=%b addr=%h want 1/0/0040", mem_req, mem_wr, mem_addr); end
        for (int i = 1; i <= 3; i++) begin
            if (ex_ready == 1'b0) low++;
            if (i == 3) begin mem_done = 1'b1; mem_rdata = 16'hBEEF; end
            step();
        end
        mem_done = 1'b0; mem_rdata = 16'h0000; ex_valid = 1'b0;
        if (ex_ready == 1'b0) low++;
        vectors++; if (wb_valid !== 1'b1 || wb_data !== 16'hBEEF || wb_err !== 1'b0) begin miscompares++; $display("FAIL load_wb got v=%b d=%h e=%b want 1/beef/0", wb_valid, wb_data, wb_err); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL load_req_drop got %b want 0", mem_req); end
        step();
        vectors++; if (low != 4) begin miscompares++; $display("FAIL load_stall got %0d want 4", low); end
        vectors++; if (ex_ready !== 1'b1 || wb_valid !== 1'b0) begin miscompares++; $display("FAIL load_after got rdy=%b wbv=%b want 1/0", ex_ready, wb_valid); end
    endtask

    task automatic test_store();
        present(16'h0010, 16'h00AA, 1'b0, 1'b1, 1'b0);
        step();
        ex_valid = 1'b0;
        vectors++; if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_wdata !== 16'h00AA || mem_addr !== 16'h0010) begin miscompares++; $display("FAIL store_req got req=%b wr=%b wd=%h a=%h want 1/1/00aa/0010", mem_req, mem_wr, mem_wdata, mem_addr); end
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        vectors++; if (wb_valid !== 1'b1 || wb_err !== 1'b0 || wb_data !== 16'h0010) begin miscompares++; $display("FAIL store_wb got v=%b e=%b d=%h want 1/0/0010", wb_valid, wb_err, wb_data); end
        step();
    endtask

    task automatic test_timeout();
        int n = 0;
        present(16'h0020, 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < 40 && mem_req === 1'b1; i++) begin
            n++;
            step();
        end
        vectors++; if (n != 15) begin miscompares++; $display("FAIL timeout_cycles got %0d want 15", n); end
        vectors++; if (wb_valid !== 1'b1 || wb_err !== 1'b1 || wb_data !== 16'h0000 || mem_req !== 1'b0) begin miscompares++; $display("FAIL timeout_wb got v=%b e=%b d=%h req=%b want 1/1/0000/0", wb_valid, wb_err, wb_data, mem_req); end
        step();
    endtask

    task automatic test_done_at_limit();
        present(16'h0022, 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        ex_valid = 1'b0;
        for (int i = 1; i <= 14; i++) step();
        mem_done = 1'b1; mem_rdata = 16'h1357;
        step();
        mem_done = 1'b0;
        vectors++; if (wb_valid !== 1'b1 || wb_err !== 1'b0 || wb_data !== 16'h1357) begin miscompares++; $display("FAIL limit_done got v=%b e=%b d=%h want 1/0/1357", wb_valid, wb_err, wb_data); end
        step();
    endtask

    task automatic test_reset_in_req();
        int seen = 0;
        present(16'h0030, 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        ex_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (mem_req !== 1'b0 || wb_valid !== 1'b0 || ex_ready !== 1'b1) begin miscompares++; $display("FAIL rst_req got req=%b wbv=%b rdy=%b want 0/0/1", mem_req, wb_valid, ex_ready); end
        mem_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (wb_valid === 1'b1 || mem_req === 1'b1) seen++;
            step();
        end
        mem_done = 1'b0;
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL rst_no_wb got %0d activity cycles want 0", seen); end
    endtask

    task automatic test_both();
        present(16'h0050, 16'h0000, 1'b1, 1'b1, 1'b0);
        step();
        ex_valid = 1'b0;
        vectors++; if (wb_valid !== 1'b1 || wb_err !== 1'b1 || mem_req !== 1'b0 || ex_ready !== 1'b1) begin miscompares++; $display("FAIL both_rw got v=%b e=%b req=%b rdy=%b want 1/1/0/1", wb_valid, wb_err, mem_req, ex_ready); end
        step();
    endtask

    task automatic test_align();
`ifdef ALIGN_CHECK_EN
        present(16'h0041, 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        ex_valid = 1'b0;
        vectors++; if (wb_valid !== 1'b1 || wb_err !== 1'b1 || mem_req !== 1'b0) begin miscompares++; $display("FAIL align_err got v=%b e=%b req=%b want 1/1/0", wb_valid, wb_err, mem_req); end
        step();
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL align_noreq got %b want 0", mem_req); end
`else
        present(16'h0041, 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        ex_valid = 1'b0;
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 16'h0041) begin miscompares++; $display("FAIL odd_req got req=%b a=%h want 1/0041", mem_req, mem_addr); end
        mem_done = 1'b1; mem_rdata = 16'h00C3;
        step();
        mem_done = 1'b0;
        vectors++; if (wb_valid !== 1'b1 || wb_err !== 1'b0 || wb_data !== 16'h00C3) begin miscompares++; $display("FAIL odd_wb got v=%b e=%b d=%h want 1/0/00c3", wb_valid, wb_err, wb_data); end
`endif
        step();
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load();
        test_store();
        test_timeout();
        test_done_at_limit();
        test_reset_in_req();
        test_both();
        test_align();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: the number of cycles in REQ without mem_done before the access is aborted.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ex_valid  input  1  an execute result is presented.
REQ-005 SHALL have port ex_alu_result  input  16  the ALU result, used as the memory address for loads and stores.
REQ-006 SHALL have port ex_store_data  input  16  the store data.
REQ-007 SHALL have ports ex_mem_read and ex_mem_write  input  1 each  the load and store indicators.
REQ-008 SHALL have port ex_err  input  1  the execute-stage error.
REQ-009 SHALL have port ex_ready  output  1  accepts ex_valid this cycle; the inverse is the pipeline stall.
REQ-010 SHALL have ports mem_req, mem_wr  output  1 each; mem_addr, mem_wdata  output  16 each.
REQ-011 SHALL have ports mem_done  input  1; mem_rdata  input  16.
REQ-012 SHALL have ports wb_valid  output  1; wb_data  output  16; wb_err  output  1.

Function
REQ-013 SHALL implement the FSM states IDLE, REQ and DONE; ex_ready SHALL be 1 only in IDLE (combinational decode of the state).
REQ-014 SHALL treat a transfer as ex_valid & ex_ready sampled at a rising edge.
REQ-015 SHALL handle a non-memory transfer (neither read nor write) by staying in IDLE; in the next cycle wb_valid=1 and wb_data=ex_alu_result (latency 1).
REQ-016 SHALL handle a transfer with both read and write set by issuing no memory access; in the next cycle wb_valid=1 and wb_err=1.
REQ-017 SHALL handle a memory transfer by latching address, store data and read/write; next state REQ; mem_req=1, mem_wr=ex_mem_write, and mem_addr/mem_wdata driven from the latches for every cycle in REQ.
REQ-018 SHALL, in REQ, count cycles from 0; when mem_done is sampled high it SHALL capture mem_rdata for a load (the latched address for a store) into wb_data, go to DONE and drop mem_req.
REQ-019 SHALL, in DONE, assert wb_valid=1 for exactly one cycle and then return to IDLE; back-to-back memory operations therefore have a minimum period of mem-latency+2 cycles.
REQ-020 SHALL, if the counter reaches MAX_WAIT without mem_done, go to DONE with wb_err=1, wb_data=0 and mem_req dropped.
REQ-021 SHALL set wb_err = latched ex_err OR the error conditions of REQ-016, REQ-020 and REQ-028.
REQ-022 SHALL ignore mem_done outside REQ.
REQ-023 SHALL ignore ex_valid outside IDLE.
REQ-024 SHALL keep wb_valid 0 except on completion cycles; wb_data is don't-care when wb_valid=0 but SHALL NOT be X after reset.
REQ-025 SHALL let mem_done sampled high in the same cycle the counter reaches MAX_WAIT win, and complete normally.

Reset
REQ-026 SHALL make rst high at an edge force state=IDLE, counter=0 and all latches=0, so that mem_req=0, mem_wr=0, wb_valid=0, wb_err=0 and wb_data=0 in the next cycle.
REQ-027 SHALL, on reset during REQ, abandon the outstanding access without producing wb_valid.

Configuration
REQ-028 SHALL, with ALIGN_CHECK_EN defined, treat a memory transfer with ex_alu_result[0]=1 as issuing no request; wb_valid=1 and wb_err=1 one cycle later.
REQ-029 SHALL, without ALIGN_CHECK_EN, pass the address unchanged and never raise an alignment error.

Structure
REQ-030 SHALL place the state encodings (IDLE=2'b00, REQ=2'b01, DONE=2'b10) and the MAX_WAIT default in a shared defines file, mem_access_defs.
REQ-031 SHALL put the state register and wait counter in one sub-module, mem_access_fsm; the datapath latches stay in the top level.
REQ-032 SHALL build all state elements from the team's synchronous-reset flop primitive.

Verification
REQ-033 SHALL cover: non-memory op ex_alu_result=16'h1234 -> wb_valid and wb_data=16'h1234 the next cycle, ex_ready held 1.
REQ-034 SHALL cover: load at 16'h0040 with mem_done 3 cycles after mem_req and mem_rdata=16'hBEEF -> wb_data=16'hBEEF, ex_ready low for 4 cycles.
REQ-035 SHALL cover: store at 16'h0010 with data 16'h00AA -> mem_wr=1, mem_wdata=16'h00AA, wb_err=0.
REQ-036 SHALL cover: mem_done never asserted -> abort after 15 cycles in REQ with wb_err=1 and mem_req=0.
REQ-037 SHALL cover: rst asserted during cycle 2 of REQ -> mem_req=0 and no wb_valid.
REQ-038 SHALL cover: with ALIGN_CHECK_EN, load at 16'h0041 -> mem_req never asserted, wb_err=1 after 1 cycle.
